timer_ctrl: RTL and testbench
=============================

TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the count width in bits.
REQ-002 The block SHALL have port clock  input  1  the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port start  input  1  single-cycle request to begin or resume timing.
REQ-005 The block SHALL have port stop  input  1  single-cycle request to pause timing.
REQ-006 The block SHALL have port clear  input  1  single-cycle request to abort and zero the count.
REQ-007 The block SHALL have port tick  input  1  one-cycle count strobe; the count advances only on a tick.
REQ-008 The block SHALL have port mode  input  1  0 = count up from 0 to preset, 1 = count down from preset to 0; sampled in LOAD only.
REQ-009 The block SHALL have port preset  input  N  terminal value (up mode) or start value (down mode); sampled in LOAD only.
REQ-010 The block SHALL have port count  output  N  current timer value.
REQ-011 The block SHALL have port running  output  1  high while in RUN.
REQ-012 The block SHALL have port done  output  1  one-cycle pulse on entry to DONE.
REQ-013 The block SHALL have port state  output  3  current FSM state encoding.

Function
REQ-014 The FSM SHALL have the states IDLE, LOAD, RUN, PAUSE and DONE.
REQ-015 Command priority SHALL be clear > stop > start in every state.
REQ-016 A clear in any state SHALL force the next state to IDLE and count to 0 on the following edge.
REQ-017 A start in IDLE or DONE SHALL move the FSM to LOAD.
REQ-018 LOAD SHALL last exactly one cycle and SHALL load count with preset (mode=1) or with 0 (mode=0), latching mode internally.
REQ-019 From LOAD the FSM SHALL go to DONE if the loaded value is already terminal (down: preset=0; up: preset=0), otherwise to RUN.
REQ-020 In RUN, count SHALL change by exactly 1 per tick: decrement in down mode, increment in up mode; without a tick it SHALL hold.
REQ-021 In RUN, a tick that makes count reach the terminal value (0 down, preset up) SHALL move the FSM to DONE on the same edge.
REQ-022 A stop in RUN SHALL move the FSM to PAUSE; a tick in the same cycle SHALL be ignored.
REQ-023 A start in PAUSE SHALL return the FSM to RUN with count unchanged; tick SHALL have no effect in PAUSE.
REQ-024 A start in RUN or LOAD, and a stop in IDLE, PAUSE or DONE, SHALL be ignored.
REQ-025 DONE SHALL hold count at the terminal value until start (restart via LOAD) or clear.
REQ-026 The done output SHALL be high only during the first cycle in DONE.
REQ-027 The count SHALL never wrap; the terminal check SHALL prevent underflow below 0 and overflow past preset.
REQ-028 The latched preset used for the up-mode terminal compare SHALL be the value captured in LOAD, not the live input.

Reset
REQ-029 The reset input SHALL take precedence over every other input.
REQ-030 While reset is high, the block SHALL drive state=IDLE, count=0, running=0 and done=0 on the next edge.
REQ-031 A reset asserted mid-RUN SHALL discard the latched mode and preset.

Structure
REQ-032 A shared package timer_pkg SHALL hold the state enum type (3-bit, IDLE=0, LOAD=1, RUN=2, PAUSE=3, DONE=4) and the default width constant.
REQ-033 The counting datapath SHALL be one instance of the existing counter_nbit sub-module, connected as follows: reset = reset|clear; load = in LOAD; load_value = mode?preset:0; dec = latched mode; enable = in RUN & tick & !stop & !clear.
REQ-034 The FSM next-state logic SHALL be combinational and the state register synchronous.

Verification
REQ-035 Down-mode scenario: mode=1, preset=3, start, then 3 ticks -> count 3,2,1,0; done pulses once on the cycle count first reads 0; state is DONE.
REQ-036 Up-mode scenario: mode=0, preset=5, start, then 5 ticks -> count 0..5; done pulses once at 5; a 6th tick leaves count at 5.
REQ-037 Pause scenario: down, preset=10, 2 ticks, stop together with a tick -> count stays 8 in PAUSE through 3 ticks; start, 1 tick -> count 7.
REQ-038 Clear-priority scenario: RUN at count 6, clear+stop+start asserted together -> next cycle state is IDLE and count is 0; done is not asserted.
REQ-039 Zero-preset scenario: mode=1, preset=0, start -> LOAD, then DONE; done pulses once and count is 0.
REQ-040 Reset scenario: reset asserted mid-RUN at count 4 -> next cycle state is IDLE, count is 0, running is 0; ticks are ignored until start.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding and default count width for the timer block
package timer_pkg;
    localparam int TIMER_W = 8;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;
endpackage

// File: rtl/timer_ctrl_if.sv
// timer_ctrl_if: command inputs and status outputs of the timer controller
interface timer_ctrl_if import timer_pkg::*; #(parameter int N = TIMER_W);
    logic         start;
    logic         stop;
    logic         clear;
    logic         tick;
    logic         mode;
    logic [N-1:0] preset;
    logic [N-1:0] count;
    logic         running;
    logic         done;
    logic [2:0]   state;
    modport master(output start, stop, clear, tick, mode, preset, input count, running, done, state);
    modport slave(input start, stop, clear, tick, mode, preset, output count, running, done, state);
endinterface

// File: rtl/counter_nbit.sv
// counter_nbit: loadable up/down counter with synchronous reset and count enable
module counter_nbit import timer_pkg::*; #(parameter int N = TIMER_W) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] load_value,
    input  logic         dec,
    input  logic         enable,
    output logic [N-1:0] count
);
    logic [N-1:0] count_q, count_d;
    always_comb begin
        count_d = load ? load_value : enable ? (dec ? count_q - 1'b1 : count_q + 1'b1) : count_q;
    end
    always_ff @(posedge clock) begin
        if (reset) count_q <= '0;
        else count_q <= count_d;
    end
    assign count = count_q;
endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: start/stop/clear timer FSM driving an up/down counter to a terminal value
module timer_ctrl import timer_pkg::*; #(parameter int N = TIMER_W) (
    input logic         clock,
    input logic         reset,
    timer_ctrl_if.slave bus
);
    state_t       state_q, state_d;
    logic         mode_q, mode_d;
    logic [N-1:0] preset_q, preset_d;
    logic         done_q, done_d;
    logic [N-1:0] count;
    logic         go;
    logic         term_tick;
    always_comb begin
        go        = bus.start && !bus.stop;
        term_tick = bus.tick && (mode_q ? count == N'(1) : count == preset_q - N'(1));
        state_d   = state_q;
        if (bus.clear) state_d = IDLE;
        else case (state_q)
            IDLE, DONE: state_d = go ? LOAD : state_q;
            LOAD:       state_d = bus.preset == '0 ? DONE : RUN;
            RUN:        state_d = bus.stop ? PAUSE : term_tick ? DONE : RUN;
            PAUSE:      state_d = go ? RUN : PAUSE;
            default:    state_d = IDLE;
        endcase
        mode_d   = state_q == LOAD ? bus.mode : mode_q;
        preset_d = state_q == LOAD ? bus.preset : preset_q;
        done_d   = state_d == DONE && state_q != DONE;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            mode_q   <= 1'b0;
            preset_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            preset_q <= preset_d;
            done_q   <= done_d;
        end
    end
    counter_nbit #(.N(N)) u_cnt (
        .clock      (clock),
        .reset      (reset || bus.clear),
        .load       (state_q == LOAD),
        .load_value (bus.mode ? bus.preset : '0),
        .dec        (mode_q),
        .enable     (state_q == RUN && bus.tick && !bus.stop && !bus.clear),
        .count      (count)
    );
    assign bus.count   = count;
    assign bus.running = state_q == RUN;
    assign bus.done    = done_q;
    assign bus.state   = state_q;
endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: table vectors, directed corner sequences and a randomized model comparison
module tb_timer_ctrl;
    import timer_pkg::*;
    logic clk = 1'b0;
    logic rst;
    timer_ctrl_if #(.N(8)) ifc ();
    timer_ctrl #(.N(8)) dut (.clock(clk), .reset(rst), .bus(ifc));
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    state_t m_st;
    int     m_cnt;
    int     m_pre;
    bit     m_mode;
    bit     m_done;

    typedef struct {
        logic       r, s, p, c, t, m;
        logic [7:0] pr;
        state_t     st;
        logic [7:0] cnt;
        logic       run, dn;
    } vec_t;
    vec_t tbl[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic expect4(input string nm, input state_t st, input int cnt, input bit run, input bit dn);
        chk({nm, " state"}, 32'(ifc.state), 32'(st));
        chk({nm, " count"}, 32'(ifc.count), 32'(cnt));
        chk({nm, " running"}, 32'(ifc.running), 32'(run));
        chk({nm, " done"}, 32'(ifc.done), 32'(dn));
    endtask

    // Reference behaviour written straight from the command rules
    task automatic model(input logic r, s, p, c, t, m, input logic [7:0] pr);
        m_done = 0;
        if (r) begin
            m_st = IDLE; m_cnt = 0; m_mode = 0; m_pre = 0;
        end else if (c) begin
            m_st = IDLE; m_cnt = 0;
        end else if (m_st == LOAD) begin
            m_mode = m; m_pre = int'(pr);
            m_cnt  = m ? int'(pr) : 0;
            m_st   = pr == 0 ? DONE : RUN;
            m_done = pr == 0;
        end else if (m_st == RUN && p) begin
            m_st = PAUSE;
        end else if (m_st == RUN && t) begin
            m_cnt += m_mode ? -1 : 1;
            if (m_cnt == (m_mode ? 0 : m_pre)) begin
                m_st = DONE; m_done = 1;
            end
        end else if ((m_st == IDLE || m_st == DONE) && s && !p) begin
            m_st = LOAD;
        end else if (m_st == PAUSE && s && !p) begin
            m_st = RUN;
        end
    endtask

    task automatic drive(input logic r, s, p, c, t, m, input logic [7:0] pr);
        rst = r; ifc.start = s; ifc.stop = p; ifc.clear = c; ifc.tick = t; ifc.mode = m; ifc.preset = pr;
        model(r, s, p, c, t, m, pr);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ifc.start = 0; ifc.stop = 0; ifc.clear = 0; ifc.tick = 0; ifc.mode = 0; ifc.preset = 0;
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 8'd0, IDLE,  8'd0, 0, 0};
        tbl[1]  = '{0, 1, 0, 0, 0, 1, 8'd3, LOAD,  8'd0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 1, 8'd3, RUN,   8'd3, 1, 0};
        tbl[3]  = '{0, 0, 0, 0, 1, 1, 8'd3, RUN,   8'd2, 1, 0};
        tbl[4]  = '{0, 0, 0, 0, 1, 1, 8'd3, RUN,   8'd1, 1, 0};
        tbl[5]  = '{0, 0, 0, 0, 1, 1, 8'd3, DONE,  8'd0, 0, 1};
        tbl[6]  = '{0, 0, 0, 0, 1, 1, 8'd3, DONE,  8'd0, 0, 0};
        tbl[7]  = '{0, 0, 1, 0, 0, 1, 8'd3, DONE,  8'd0, 0, 0};
        tbl[8]  = '{0, 1, 0, 0, 0, 0, 8'd5, LOAD,  8'd0, 0, 0};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 8'd5, RUN,   8'd0, 1, 0};
        tbl[10] = '{0, 0, 0, 0, 1, 0, 8'd2, RUN,   8'd1, 1, 0};
        tbl[11] = '{0, 0, 0, 0, 1, 0, 8'd2, RUN,   8'd2, 1, 0};
        tbl[12] = '{0, 0, 0, 0, 1, 0, 8'd2, RUN,   8'd3, 1, 0};
        tbl[13] = '{0, 0, 0, 0, 1, 0, 8'd2, RUN,   8'd4, 1, 0};
        tbl[14] = '{0, 0, 0, 0, 1, 0, 8'd2, DONE,  8'd5, 0, 1};
        tbl[15] = '{0, 0, 0, 0, 1, 0, 8'd2, DONE,  8'd5, 0, 0};
        #2;
        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].s, tbl[i].p, tbl[i].c, tbl[i].t, tbl[i].m, tbl[i].pr);
            expect4($sformatf("vec%0d", i), tbl[i].st, int'(tbl[i].cnt), tbl[i].run, tbl[i].dn);
        end

        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 1, 10);
        drive(0, 0, 0, 0, 0, 1, 10);
        drive(0, 0, 0, 0, 1, 1, 10);
        drive(0, 0, 0, 0, 1, 1, 10);
        expect4("pause pre", RUN, 8, 1, 0);
        drive(0, 0, 1, 0, 1, 1, 10);
        expect4("pause stop", PAUSE, 8, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 1, 1, 10);
            expect4($sformatf("pause tick%0d", i), PAUSE, 8, 0, 0);
        end
        drive(0, 1, 0, 0, 0, 1, 10);
        expect4("pause resume", RUN, 8, 1, 0);
        drive(0, 0, 0, 0, 1, 1, 10);
        expect4("pause after", RUN, 7, 1, 0);

        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 9);
        drive(0, 0, 0, 0, 0, 0, 9);
        for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, 1, 0, 9);
        expect4("clear pre", RUN, 6, 1, 0);
        drive(0, 1, 1, 1, 1, 0, 9);
        expect4("clear prio", IDLE, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 9);
        expect4("clear hold", IDLE, 0, 0, 0);

        drive(0, 1, 0, 0, 0, 1, 0);
        expect4("zero load", LOAD, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        expect4("zero done", DONE, 0, 0, 1);
        drive(0, 0, 0, 0, 1, 1, 0);
        expect4("zero after", DONE, 0, 0, 0);

        drive(0, 1, 0, 0, 0, 1, 9);
        drive(0, 0, 0, 0, 0, 1, 9);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 1, 1, 9);
        expect4("reset pre", RUN, 4, 1, 0);
        drive(1, 0, 0, 0, 1, 1, 9);
        expect4("reset mid", IDLE, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 1, 1, 9);
            expect4($sformatf("reset tick%0d", i), IDLE, 0, 0, 0);
        end

        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 31) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  8'($urandom_range(0, 12)));
            expect4($sformatf("rand%0d", i), m_st, m_cnt, m_st == RUN, m_done);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
